// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle digit-serial adder/subtractor.
// Operands are captured on start, then one NW-bit digit is processed per clock, LSB digit first.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               request, accepted only in IDLE
//   mode[1:0]           00/11 chained add, 01 chained sub (A-B), 10 per-nibble add
//   A, B                operands, sampled when start is accepted
//   busy                high while digits are being computed
//   done                one-cycle pulse, result valid
//   sum                 result digits
//   carry_vec           carry out of each digit (bit i = digit i)
//   cout                carry out of the top digit; in sub mode 1 = no borrow
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned NW      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [NIBBLES*NW-1:0] A,
  input  logic [NIBBLES*NW-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [NIBBLES*NW-1:0] sum,
  output logic [NIBBLES-1:0]    carry_vec,
  output logic                  cout
);

  localparam int unsigned W  = NIBBLES * NW;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              sub_q, sub_d;
  logic              pn_q, pn_d;
  logic              cin_q, cin_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [NIBBLES-1:0] cvec_q, cvec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NW-1:0]     a_dig_c;
  logic [NW-1:0]     b_dig_c;
  logic              dig_cin_c;
  logic [NW:0]       dig_c;

  // Current digit: B is inverted in sub mode; per-nibble mode never chains the carry.
  always_comb begin
    a_dig_c   = a_q[NW*idx_q +: NW];
    b_dig_c   = sub_q ? ~b_q[NW*idx_q +: NW] : b_q[NW*idx_q +: NW];
    dig_cin_c = pn_q ? 1'b0 : cin_q;
    dig_c     = {1'b0, a_dig_c} + {1'b0, b_dig_c} + (NW+1)'(dig_cin_c);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    pn_d    = pn_q;
    cin_d   = cin_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cvec_d  = cvec_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          sub_d   = (mode == 2'b01);
          pn_d    = (mode == 2'b10);
          cin_d   = (mode == 2'b01);
          idx_d   = '0;
          sum_d   = '0;
          cvec_d  = '0;
        end
      end
      RUN: begin
        sum_d[NW*idx_q +: NW] = dig_c[NW-1:0];
        cvec_d[idx_q]         = dig_c[NW];
        cin_d                 = dig_c[NW];
        if (idx_q == IW'(NIBBLES - 1)) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    // done is registered from the DONE state so it appears one cycle after the last digit.
    done_d = (state_q == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      pn_q    <= 1'b0;
      cin_q   <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cvec_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      pn_q    <= pn_d;
      cin_q   <= cin_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cvec_q  <= cvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_vec = cvec_q;
  assign cout      = cvec_q[NIBBLES-1];

endmodule
